vending_customer: RTL and testbench
===================================

// Module: vending_customer
// PURPOSE
//  Customer-side transactor for the vending machine's coin/item interface. A host issues a
//  purchase request; the block offers coins and the item request while the machine reports ON,
//  waits through BUSY, then collects the change and item when the machine reports OFF. It keeps
//  a wallet of NTD_5/NTD_1 coins and audits every transaction: paid == change (+ COST_A if item).
//  It pairs with the vending machine in system-level benches and formal harnesses.
// PARAMETERS
//  WALLET_W      3   width of each wallet coin counter; counters saturate at 2**WALLET_W-1
//  WALLET5_INIT  2   NTD_5 coins in wallet after reset
//  WALLET1_INIT  2   NTD_1 coins in wallet after reset
//  TIMEOUT_CYC   16  max cycles from request accept to OFF before abort (>=3)
//  ITEM_W        4   width of the items_owned counter (saturating)
// PORTS
//  clk             in   1         clock, rising edge
//  reset           in   1         asynchronous, active-high reset
//  req_valid       in   1         host purchase request
//  req_ready       out  1         1 only in IDLE
//  req_coin5       in   1         insert one NTD_5 coin
//  req_coin1       in   1         insert one NTD_1 coin
//  req_item        in   1         requested item (ITEM_A=1; ITEM_NONE=0 is rejected)
//  coinInNTD_5     out  1         to machine: NTD_5 coin offered
//  coinInNTD_1     out  1         to machine: NTD_1 coin offered
//  itemTypeIn      out  1         to machine: item request
//  coinOutNTD_5    in   1         from machine: NTD_5 change
//  coinOutNTD_1    in   1         from machine: NTD_1 change
//  itemTypeOut     in   1         from machine: dispensed item
//  serviceTypeOut  in   2         from machine: OFF=00, ON=01, BUSY=10 (11 treated as BUSY)
//  rsp_valid       out  1         one-cycle result pulse
//  rsp_status      out  2         OK=0, REJECT=1, TIMEOUT=2, MISMATCH=3
//  rsp_item        out  1         item received
//  rsp_change      out  4         change value received (5*c5 + c1)
//  wallet5         out  WALLET_W  NTD_5 coins held
//  wallet1         out  WALLET_W  NTD_1 coins held
//  items_owned     out  ITEM_W    items collected since reset
// BEHAVIOUR
//  - Reset (async): state IDLE; all machine-side outputs 0; rsp_* 0; wallet5/1 = INIT; items_owned = 0;
//    timer 0. Reset mid-transaction discards in-flight coins; no response is issued.
//  - States: IDLE, OFFER, WAIT, RESP.
//  - IDLE: req_ready=1. Accept on req_valid. Reject (go to RESP, status REJECT, wallet unchanged) if
//    req_item==0 or req_coin5>wallet5 or req_coin1>wallet1. Otherwise latch request, timer=0, go to OFFER.
//  - OFFER: machine-side outputs 0 while serviceTypeOut!=ON. In the first cycle with ON, drive the latched
//    coinIn*/itemTypeIn for exactly that cycle; on that edge debit the wallet and go to WAIT.
//  - WAIT: outputs 0. On serviceTypeOut==OFF, sample coinOut*/itemTypeOut and credit the wallet
//    (saturating). items_owned += itemTypeOut (saturating). Go to RESP.
//    status = MISMATCH if paid != change + (item ? 6 : 0), else OK.
//  - Timer counts every cycle in OFFER/WAIT. On reaching TIMEOUT_CYC, go to RESP with status TIMEOUT;
//    debited coins are not refunded; rsp_item/rsp_change = 0.
//  - RESP: rsp_valid=1 for one cycle with registered fields, then IDLE. rsp_* hold 0 when rsp_valid=0.
//  - Latency: best case accept->rsp_valid = offer cycle + machine BUSY cycles + 2.
//  - Arithmetic: paid/change/expected computed in 4 bits (max 6 paid, 6+5+1 expected in 4 bits).
//  - ON seen in WAIT without an intervening OFF: keep waiting until TIMEOUT.
// STRUCTURE
//  - vending_pkg: SERVICE_OFF/ON/BUSY, NTD_5/NTD_1 values, ITEM_NONE/ITEM_A, COST_A=6, RSP_* status
//    codes, state encodings.
//  - Sub-module vending_wallet: one coin counter with debit-on-offer, saturating credit and reset init;
//    instantiated twice (NTD_5, NTD_1).
// TESTING
//  1. Wallet 2/2, machine ON, req coin5=1 coin1=1 item=1 -> OK, item=1, change=0, wallet 1/1, items=1.
//  2. Req coin5=1 coin1=0 item=1 (5<6) -> machine refunds; OK, item=0, change=5, wallet back to 2/2.
//  3. WALLET5_INIT=0, req coin5=1 -> rsp_valid next cycle, REJECT, no coinIn pulse, wallet unchanged.
//     Req item=0 -> REJECT.
//  4. serviceTypeOut held BUSY -> TIMEOUT after 16 cycles; wallet stays debited; req_ready=1 the next cycle.
//  5. Model returns OFF with item=1, coinOut1=1 for paid 6 -> MISMATCH, change=1, wallet1 credited.
//  6. Assert reset during WAIT -> outputs 0 immediately, wallet=INIT, no rsp_valid; the next request
//     completes OK.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared encodings for the vending-machine customer transactor: service codes,
// coin values, item codes, response status and FSM states.
package vending_pkg;

    localparam logic [1:0] SERVICE_OFF  = 2'b00;
    localparam logic [1:0] SERVICE_ON   = 2'b01;
    localparam logic [1:0] SERVICE_BUSY = 2'b10;

    localparam logic [3:0] NTD_5 = 4'd5;
    localparam logic [3:0] NTD_1 = 4'd1;

    localparam logic ITEM_NONE = 1'b0;
    localparam logic ITEM_A    = 1'b1;

    localparam logic [3:0] COST_A = 4'd6;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_REJECT   = 2'd1,
        RSP_TIMEOUT  = 2'd2,
        RSP_MISMATCH = 2'd3
    } rsp_status_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // 4-bit NTD value of a one-coin-each offer or refund
    function automatic logic [3:0] coin_value(input logic c5, input logic c1);
        coin_value = (c5 ? NTD_5 : 4'd0) + (c1 ? NTD_1 : 4'd0);
    endfunction

endpackage

// File: rtl/vending_customer_if.sv
// Host request/response and machine coin/item signals of the customer transactor.
// master = the customer block, slave = host plus vending machine.
interface vending_customer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_coin5;
    logic       req_coin1;
    logic       req_item;
    logic       coinInNTD_5;
    logic       coinInNTD_1;
    logic       itemTypeIn;
    logic       coinOutNTD_5;
    logic       coinOutNTD_1;
    logic       itemTypeOut;
    logic [1:0] serviceTypeOut;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic       rsp_item;
    logic [3:0] rsp_change;

    modport master (
        input  req_valid, req_coin5, req_coin1, req_item,
        input  coinOutNTD_5, coinOutNTD_1, itemTypeOut, serviceTypeOut,
        output req_ready, coinInNTD_5, coinInNTD_1, itemTypeIn,
        output rsp_valid, rsp_status, rsp_item, rsp_change
    );

    modport slave (
        output req_valid, req_coin5, req_coin1, req_item,
        output coinOutNTD_5, coinOutNTD_1, itemTypeOut, serviceTypeOut,
        input  req_ready, coinInNTD_5, coinInNTD_1, itemTypeIn,
        input  rsp_valid, rsp_status, rsp_item, rsp_change
    );
endinterface

// File: rtl/vending_wallet.sv
// One wallet coin counter: reset to INIT, debit one coin when offered,
// credit one coin on change with saturation at all-ones.
module vending_wallet #(
    parameter int WALLET_W = 3,
    parameter int INIT     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_debit,
    input  logic                i_credit,
    output logic [WALLET_W-1:0] o_count
);

    localparam logic [WALLET_W-1:0] CNT_MAX  = {WALLET_W{1'b1}};
    localparam logic [WALLET_W-1:0] CNT_ONE  = WALLET_W'(1'b1);
    localparam logic [WALLET_W-1:0] CNT_INIT = WALLET_W'(INIT);

    logic [WALLET_W-1:0] r_count;
    logic [WALLET_W-1:0] w_next;

    // next count from debit/credit requests
    always_comb begin
        w_next = r_count;
        if (i_debit && !i_credit) begin
            w_next = r_count - CNT_ONE;
        end else if (i_credit && !i_debit && (r_count != CNT_MAX)) begin
            w_next = r_count + CNT_ONE;
        end else begin
            w_next = r_count;
        end
    end

    // counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= CNT_INIT;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vending_customer.sv
// Customer-side transactor: offers coins/item to the vending machine while it is ON,
// collects change when it returns to OFF, and audits paid == change + item cost.
module vending_customer
    import vending_pkg::*;
#(
    parameter int WALLET_W     = 3,
    parameter int WALLET5_INIT = 2,
    parameter int WALLET1_INIT = 2,
    parameter int TIMEOUT_CYC  = 16,
    parameter int ITEM_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    vending_customer_if.master  bus,
    output logic [WALLET_W-1:0] wallet5,
    output logic [WALLET_W-1:0] wallet1,
    output logic [ITEM_W-1:0]   items_owned
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1'b1);
    localparam logic [ITEM_W-1:0] ITEM_MAX = {ITEM_W{1'b1}};
    localparam logic [ITEM_W-1:0] ITEM_ONE = ITEM_W'(1'b1);

    state_t            r_state;
    state_t            w_next;
    logic              r_c5;
    logic              r_c1;
    logic              r_item;
    logic [TMR_W-1:0]  r_timer;
    logic              r_rsp_valid;
    logic [1:0]        r_rsp_status;
    logic              r_rsp_item;
    logic [3:0]        r_rsp_change;
    logic [ITEM_W-1:0] r_items;

    logic       w_accept;
    logic       w_reject;
    logic       w_offer;
    logic       w_collect;
    logic       w_timeout;
    logic       w_timer_last;
    logic [3:0] w_paid;
    logic [3:0] w_change;
    logic [3:0] w_expected;

    assign w_timer_last = (r_timer == TMR_LAST);
    assign w_paid       = coin_value(r_c5, r_c1);
    assign w_change     = coin_value(bus.coinOutNTD_5, bus.coinOutNTD_1);
    assign w_expected   = w_change + (bus.itemTypeOut ? COST_A : 4'd0);

    // next-state and transaction events; a machine event wins over a same-cycle timeout
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        w_offer   = 1'b0;
        w_collect = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if ((bus.req_item == ITEM_NONE) ||
                        (bus.req_coin5 && (wallet5 == {WALLET_W{1'b0}})) ||
                        (bus.req_coin1 && (wallet1 == {WALLET_W{1'b0}}))) begin
                        w_reject = 1'b1;
                        w_next   = ST_RESP;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = ST_OFFER;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (bus.serviceTypeOut == SERVICE_ON) begin
                    w_offer = 1'b1;
                    w_next  = ST_WAIT;
                end else if (w_timer_last) begin
                    w_timeout = 1'b1;
                    w_next    = ST_RESP;
                end else begin
                    w_next = ST_OFFER;
                end
            end
            ST_WAIT: begin
                if (bus.serviceTypeOut == SERVICE_OFF) begin
                    w_collect = 1'b1;
                    w_next    = ST_RESP;
                end else if (w_timer_last) begin
                    w_timeout = 1'b1;
                    w_next    = ST_RESP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // machine-side offer is live only in the ON cycle of OFFER
    always_comb begin
        bus.req_ready   = (r_state == ST_IDLE);
        bus.coinInNTD_5 = w_offer & r_c5;
        bus.coinInNTD_1 = w_offer & r_c1;
        bus.itemTypeIn  = w_offer & r_item;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // latched request and transaction timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c5    <= 1'b0;
            r_c1    <= 1'b0;
            r_item  <= 1'b0;
            r_timer <= {TMR_W{1'b0}};
        end else if (w_accept) begin
            r_c5    <= bus.req_coin5;
            r_c1    <= bus.req_coin1;
            r_item  <= bus.req_item;
            r_timer <= {TMR_W{1'b0}};
        end else if ((r_state == ST_OFFER) || (r_state == ST_WAIT)) begin
            r_timer <= r_timer + TMR_ONE;
        end else begin
            r_timer <= r_timer;
        end
    end

    // response fields, zero whenever no pulse is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= RSP_OK;
            r_rsp_item   <= 1'b0;
            r_rsp_change <= 4'd0;
        end else begin
            r_rsp_valid <= w_reject | w_collect | w_timeout;
            if (w_collect) begin
                r_rsp_status <= (w_paid != w_expected) ? RSP_MISMATCH : RSP_OK;
                r_rsp_item   <= bus.itemTypeOut;
                r_rsp_change <= w_change;
            end else if (w_reject) begin
                r_rsp_status <= RSP_REJECT;
                r_rsp_item   <= 1'b0;
                r_rsp_change <= 4'd0;
            end else if (w_timeout) begin
                r_rsp_status <= RSP_TIMEOUT;
                r_rsp_item   <= 1'b0;
                r_rsp_change <= 4'd0;
            end else begin
                r_rsp_status <= RSP_OK;
                r_rsp_item   <= 1'b0;
                r_rsp_change <= 4'd0;
            end
        end
    end

    // collected-item counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_items <= {ITEM_W{1'b0}};
        end else if (w_collect && bus.itemTypeOut && (r_items != ITEM_MAX)) begin
            r_items <= r_items + ITEM_ONE;
        end else begin
            r_items <= r_items;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_item   = r_rsp_item;
    assign bus.rsp_change = r_rsp_change;
    assign items_owned    = r_items;

    vending_wallet #(.WALLET_W(WALLET_W), .INIT(WALLET5_INIT)) u_wallet5 (
        .clk      (clk),
        .reset    (reset),
        .i_debit  (w_offer & r_c5),
        .i_credit (w_collect & bus.coinOutNTD_5),
        .o_count  (wallet5)
    );

    vending_wallet #(.WALLET_W(WALLET_W), .INIT(WALLET1_INIT)) u_wallet1 (
        .clk      (clk),
        .reset    (reset),
        .i_debit  (w_offer & r_c1),
        .i_credit (w_collect & bus.coinOutNTD_1),
        .o_count  (wallet1)
    );

endmodule

// File: tb/tb_vending_customer.sv
// Directed, table-driven bench for vending_customer with a scripted vending-machine
// responder; hand-sequenced reset-in-WAIT case at the end.
module tb_vending_customer;
    import vending_pkg::*;

    localparam int M_NORMAL  = 0;
    localparam int M_REJECT  = 1;
    localparam int M_BUSY_TO = 2;
    localparam int M_ON_TO   = 3;
    localparam int N_VEC     = 10;

    typedef struct {
        logic       c5;
        logic       c1;
        logic       item;
        int         mode;
        int         pre;
        int         busy;
        logic       o5;
        logic       o1;
        logic       oitem;
        logic [1:0] st;
        logic       e_item;
        logic [3:0] e_change;
        logic [2:0] w5;
        logic [2:0] w1;
        logic [3:0] items;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [2:0] wallet5;
    logic [2:0] wallet1;
    logic [3:0] items_owned;
    int         n_tests;
    int         n_fail;
    int         cur_idx;
    vec_t       vecs[N_VEC];
    vec_t       rv;

    vending_customer_if bus();

    vending_customer #(
        .WALLET_W(3), .WALLET5_INIT(2), .WALLET1_INIT(2), .TIMEOUT_CYC(16), .ITEM_W(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .wallet5     (wallet5),
        .wallet1     (wallet1),
        .items_owned (items_owned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, cur_idx, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid      = 1'b0;
        bus.req_coin5      = 1'b0;
        bus.req_coin1      = 1'b0;
        bus.req_item       = 1'b0;
        bus.coinOutNTD_5   = 1'b0;
        bus.coinOutNTD_1   = 1'b0;
        bus.itemTypeOut    = 1'b0;
        bus.serviceTypeOut = SERVICE_OFF;
    endtask

    // one host transaction against a scripted machine; called at a negedge in IDLE
    task automatic run_txn(input vec_t v);
        int   n;
        logic extra;
        extra = 1'b0;
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_coin5 = v.c5;
        bus.req_coin1 = v.c1;
        bus.req_item  = v.item;
        bus.serviceTypeOut = SERVICE_OFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_coin5 = 1'b0;
        bus.req_coin1 = 1'b0;
        bus.req_item  = 1'b0;
        if (v.mode != M_REJECT) begin
            check("req_ready_busy", bus.req_ready, 0);
            for (int i = 0; i < v.pre; i++) begin
                bus.serviceTypeOut = (i % 2 == 0) ? SERVICE_BUSY : 2'b11;
                #1 extra = extra | bus.coinInNTD_5 | bus.coinInNTD_1 | bus.itemTypeIn;
                @(negedge clk);
            end
            n = v.pre;
            if (v.mode == M_BUSY_TO) begin
                bus.serviceTypeOut = SERVICE_BUSY;
            end else begin
                bus.serviceTypeOut = SERVICE_ON;
                #1;
                check("coinIn5_pulse", bus.coinInNTD_5, v.c5);
                check("coinIn1_pulse", bus.coinInNTD_1, v.c1);
                check("itemIn_pulse", bus.itemTypeIn, v.item);
                @(negedge clk);
                n++;
                if (v.mode == M_NORMAL) begin
                    bus.serviceTypeOut = SERVICE_BUSY;
                end
            end
            if (v.mode == M_NORMAL) begin
                for (int i = 0; i < v.busy; i++) begin
                    #1 extra = extra | bus.coinInNTD_5 | bus.coinInNTD_1 | bus.itemTypeIn;
                    @(negedge clk);
                end
                bus.serviceTypeOut = SERVICE_OFF;
                bus.coinOutNTD_5   = v.o5;
                bus.coinOutNTD_1   = v.o1;
                bus.itemTypeOut    = v.oitem;
                @(negedge clk);
                bus.coinOutNTD_5   = 1'b0;
                bus.coinOutNTD_1   = 1'b0;
                bus.itemTypeOut    = 1'b0;
            end else begin
                while (!bus.rsp_valid && n < 40) begin
                    #1 extra = extra | bus.coinInNTD_5 | bus.coinInNTD_1 | bus.itemTypeIn;
                    @(negedge clk);
                    n++;
                end
                bus.serviceTypeOut = SERVICE_OFF;
                check("timeout_cycles", n, 16);
            end
            check("no_extra_offer", extra, 0);
        end
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_status", bus.rsp_status, v.st);
        check("rsp_item", bus.rsp_item, v.e_item);
        check("rsp_change", bus.rsp_change, v.e_change);
        check("wallet5", wallet5, v.w5);
        check("wallet1", wallet1, v.w1);
        check("items_owned", items_owned, v.items);
        @(negedge clk);
        check("rsp_valid_drop", bus.rsp_valid, 0);
        check("rsp_status_zero", bus.rsp_status, 0);
        check("req_ready_after", bus.req_ready, 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cur_idx = -1;
        clear_inputs();

        //           c5    c1    item  mode       pre busy o5    o1    oitem st            itm   chg   w5    w1    items
        vecs[0] = '{1'b1, 1'b1, 1'b1, M_NORMAL,  0,  2,  1'b0, 1'b0, 1'b1, RSP_OK,       1'b1, 4'd0, 3'd1, 3'd1, 4'd1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, M_NORMAL,  1,  1,  1'b1, 1'b0, 1'b0, RSP_OK,       1'b0, 4'd5, 3'd1, 3'd1, 4'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, M_REJECT,  0,  0,  1'b0, 1'b0, 1'b0, RSP_REJECT,   1'b0, 4'd0, 3'd1, 3'd1, 4'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, M_NORMAL,  3,  0,  1'b0, 1'b1, 1'b1, RSP_MISMATCH, 1'b1, 4'd1, 3'd0, 3'd1, 4'd2};
        vecs[4] = '{1'b1, 1'b0, 1'b1, M_REJECT,  0,  0,  1'b0, 1'b0, 1'b0, RSP_REJECT,   1'b0, 4'd0, 3'd0, 3'd1, 4'd2};
        vecs[5] = '{1'b0, 1'b1, 1'b1, M_BUSY_TO, 0,  0,  1'b0, 1'b0, 1'b0, RSP_TIMEOUT,  1'b0, 4'd0, 3'd0, 3'd1, 4'd2};
        vecs[6] = '{1'b0, 1'b1, 1'b1, M_ON_TO,   0,  0,  1'b0, 1'b0, 1'b0, RSP_TIMEOUT,  1'b0, 4'd0, 3'd0, 3'd0, 4'd2};
        vecs[7] = '{1'b0, 1'b1, 1'b1, M_REJECT,  0,  0,  1'b0, 1'b0, 1'b0, RSP_REJECT,   1'b0, 4'd0, 3'd0, 3'd0, 4'd2};
        vecs[8] = '{1'b0, 1'b0, 1'b1, M_NORMAL,  0,  0,  1'b1, 1'b1, 1'b0, RSP_MISMATCH, 1'b0, 4'd6, 3'd1, 3'd1, 4'd2};
        vecs[9] = '{1'b0, 1'b0, 1'b1, M_NORMAL,  0,  1,  1'b0, 1'b0, 1'b0, RSP_OK,       1'b0, 4'd0, 3'd1, 3'd1, 4'd2};

        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_coinIn5", bus.coinInNTD_5, 0);
        check("rst_coinIn1", bus.coinInNTD_1, 0);
        check("rst_itemIn", bus.itemTypeIn, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_status", bus.rsp_status, 0);
        check("rst_wallet5", wallet5, 2);
        check("rst_wallet1", wallet1, 2);
        check("rst_items", items_owned, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < N_VEC; i++) begin
            cur_idx = i;
            run_txn(vecs[i]);
        end

        // reset asserted while waiting for the machine to finish
        cur_idx = 100;
        bus.req_valid = 1'b1;
        bus.req_coin5 = 1'b1;
        bus.req_coin1 = 1'b1;
        bus.req_item  = 1'b1;
        @(negedge clk);
        clear_inputs();
        bus.serviceTypeOut = SERVICE_ON;
        @(negedge clk);
        bus.serviceTypeOut = SERVICE_BUSY;
        check("pre_rst_wallet5", wallet5, 0);
        check("pre_rst_wallet1", wallet1, 0);
        check("pre_rst_ready", bus.req_ready, 0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", bus.req_ready, 1);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_wallet5", wallet5, 2);
        check("mid_rst_wallet1", wallet1, 2);
        check("mid_rst_items", items_owned, 0);
        @(negedge clk);
        bus.serviceTypeOut = SERVICE_OFF;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_rsp", bus.rsp_valid, 0);
            @(negedge clk);
        end
        cur_idx = 101;
        rv = vecs[0];
        run_txn(rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
